// File: rtl/rst_sequencer_if.sv
// Handshake bundle between the reset sequencer and the blocks it controls:
// request/lock inputs in, per-domain resets, ready and last cause out.
interface rst_sequencer_if #(
  parameter int NUM_DOMAINS = 3
);
  logic                   sw_req_i;
  logic                   lock_i;
  logic [NUM_DOMAINS-1:0] rst_n_o;
  logic                   ready_o;
  logic [1:0]             cause_o;

  modport master (
    output sw_req_i, lock_i,
    input  rst_n_o, ready_o, cause_o
  );

  modport slave (
    input  sw_req_i, lock_i,
    output rst_n_o, ready_o, cause_o
  );
endinterface

// File: rtl/rst_sequencer.sv
// Master reset generator: hold, qualify clock lock, then release the domain
// resets one at a time in order, with software-request and lock-loss re-entry.
module rst_sequencer #(
  parameter int NUM_DOMAINS  = 3,
  parameter int HOLD_CYCLES  = 16,
  parameter int LOCK_CYCLES  = 4,
  parameter int STAGE_CYCLES = 4,
  parameter int CNT_W        = 8
) (
  input  logic            clk,
  input  logic            reset,
  rst_sequencer_if.slave  bus
);
  localparam logic [1:0] S_HOLD    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;
  localparam logic [1:0] S_RUN     = 2'd3;

  localparam logic [1:0] CAUSE_EXT  = 2'd0;
  localparam logic [1:0] CAUSE_SW   = 2'd1;
  localparam logic [1:0] CAUSE_LOCK = 2'd2;

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);
  localparam logic [NUM_DOMAINS-1:0] DOM0 = NUM_DOMAINS'(1);

  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_DOMAINS-1:0] rst_n_q, rst_n_d;
  logic                   ready_q, ready_d;
  logic [1:0]             cause_q, cause_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_n_d = rst_n_q;
    ready_d = ready_q;
    cause_d = cause_q;

    case (state_q)
      S_HOLD: begin
        rst_n_d = '0;
        ready_d = 1'b0;
        if (cnt_q == HOLD_LAST) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (!bus.lock_i) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = S_RELEASE;
          rst_n_d = DOM0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        // rst_n_q is a thermometer code; its top bit doubles as "last domain out"
        if (cnt_q == STAGE_LAST) begin
          cnt_d = '0;
          if (rst_n_q[NUM_DOMAINS-1]) begin
            ready_d = 1'b1;
            state_d = S_RUN;
          end else begin
            rst_n_d = (rst_n_q << 1) | DOM0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ready_d = 1'b1;
    endcase

    if (bus.sw_req_i) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      rst_n_d = '0;
      ready_d = 1'b0;
      cause_d = CAUSE_SW;
    end else if (!bus.lock_i && (state_q == S_RELEASE || state_q == S_RUN)) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      rst_n_d = '0;
      ready_d = 1'b0;
      cause_d = CAUSE_LOCK;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      rst_n_q <= '0;
      ready_q <= 1'b0;
      cause_q <= CAUSE_EXT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_n_q <= rst_n_d;
      ready_q <= ready_d;
      cause_q <= cause_d;
    end
  end

  assign bus.rst_n_o = rst_n_q;
  assign bus.ready_o = ready_q;
  assign bus.cause_o = cause_q;
endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with HOLD=8, LOCK=4, STAGE=2, 3 domains;
// expected edge numbers are hand-derived from the sequencing rules.
module tb_rst_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  rst_sequencer_if #(.NUM_DOMAINS(3)) bus ();

  rst_sequencer #(
    .NUM_DOMAINS(3), .HOLD_CYCLES(8), .LOCK_CYCLES(4),
    .STAGE_CYCLES(2), .CNT_W(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] rn, input logic rdy,
                         input logic [1:0] cause);
    chk({tag, ".rst_n"}, 8'(bus.rst_n_o), 8'(rn));
    chk({tag, ".ready"}, 8'(bus.ready_o), 8'(rdy));
    chk({tag, ".cause"}, 8'(bus.cause_o), 8'(cause));
  endtask

  initial begin
    bus.sw_req_i = 1'b0;
    bus.lock_i   = 1'b1;

    // 1: plain power-up with lock high throughout
    tick(2);
    chk_out("t1_reset", 3'b000, 1'b0, 2'd0);
    reset = 1'b0;
    tick(7);  chk_out("t1_E7",  3'b000, 1'b0, 2'd0);
    tick(4);  chk_out("t1_E11", 3'b000, 1'b0, 2'd0);
    tick(1);  chk_out("t1_E12", 3'b001, 1'b0, 2'd0);
    tick(1);  chk_out("t1_E13", 3'b001, 1'b0, 2'd0);
    tick(1);  chk_out("t1_E14", 3'b011, 1'b0, 2'd0);
    tick(2);  chk_out("t1_E16", 3'b111, 1'b0, 2'd0);
    tick(1);  chk_out("t1_E17", 3'b111, 1'b0, 2'd0);
    tick(1);  chk_out("t1_E18", 3'b111, 1'b1, 2'd0);

    // 2: lock low at E10 restarts qualification
    reset = 1'b1; tick(1); reset = 1'b0;
    tick(9);
    bus.lock_i = 1'b0; tick(1); bus.lock_i = 1'b1;
    tick(3);  chk_out("t2_E13", 3'b000, 1'b0, 2'd0);
    tick(1);  chk_out("t2_E14", 3'b001, 1'b0, 2'd0);
    tick(4);  chk_out("t2_E18", 3'b111, 1'b0, 2'd0);
    tick(1);  chk_out("t2_E19", 3'b111, 1'b0, 2'd0);
    tick(1);  chk_out("t2_E20", 3'b111, 1'b1, 2'd0);

    // 3: software request from RUN replays the full sequence
    bus.sw_req_i = 1'b1; tick(1); bus.sw_req_i = 1'b0;
    chk_out("t3_P", 3'b000, 1'b0, 2'd1);
    tick(11); chk_out("t3_P11", 3'b000, 1'b0, 2'd1);
    tick(1);  chk_out("t3_P12", 3'b001, 1'b0, 2'd1);
    tick(2);  chk_out("t3_P14", 3'b011, 1'b0, 2'd1);
    tick(2);  chk_out("t3_P16", 3'b111, 1'b0, 2'd1);
    tick(1);  chk_out("t3_P17", 3'b111, 1'b0, 2'd1);
    tick(1);  chk_out("t3_P18", 3'b111, 1'b1, 2'd1);

    // 4: lock loss while rst_n_o=011
    bus.sw_req_i = 1'b1; tick(1); bus.sw_req_i = 1'b0;
    tick(12); chk_out("t4_P12", 3'b001, 1'b0, 2'd1);
    tick(2);  chk_out("t4_P14", 3'b011, 1'b0, 2'd1);
    bus.lock_i = 1'b0; tick(1); bus.lock_i = 1'b1;
    chk_out("t4_D", 3'b000, 1'b0, 2'd2);
    for (int i = 1; i <= 11; i++) begin
      tick(1);
      chk("t4_hold.rst_n", 8'(bus.rst_n_o), 8'h00);
    end
    tick(1);  chk_out("t4_D12", 3'b001, 1'b0, 2'd2);
    tick(2);  chk_out("t4_D14", 3'b011, 1'b0, 2'd2);
    tick(2);  chk_out("t4_D16", 3'b111, 1'b0, 2'd2);
    tick(2);  chk_out("t4_D18", 3'b111, 1'b1, 2'd2);

    // 5: priority sw over lock loss, reset over sw
    bus.sw_req_i = 1'b1; bus.lock_i = 1'b0; tick(1);
    bus.sw_req_i = 1'b0; bus.lock_i = 1'b1;
    chk_out("t5_sw_lock", 3'b000, 1'b0, 2'd1);
    reset = 1'b1; bus.sw_req_i = 1'b1; tick(1);
    reset = 1'b0; bus.sw_req_i = 1'b0;
    chk_out("t5_rst_sw", 3'b000, 1'b0, 2'd0);

    // 6: sw request at hold count 5 restarts the hold
    tick(5);
    bus.sw_req_i = 1'b1; tick(1); bus.sw_req_i = 1'b0;
    chk_out("t6_P", 3'b000, 1'b0, 2'd1);
    tick(6);  chk_out("t6_P6",  3'b000, 1'b0, 2'd1);
    tick(5);  chk_out("t6_P11", 3'b000, 1'b0, 2'd1);
    tick(1);  chk_out("t6_P12", 3'b001, 1'b0, 2'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
